// File: rtl/morse_letter_scroller.sv
// ---------------------------------------------------------------------------
// morse_letter_scroller
//
// Purpose:
//   Sits after the Morse decoder. It captures a decoded letter code each
//   time the decoder's done level rises and queues it in a small circular
//   FIFO. Queued letters are then replayed one at a time. Each letter is
//   shown for HOLD cycles and followed by GAP blank cycles, so a 7-segment
//   display can present a readable scrolling message. The decoder's
//   per-letter timing is decoupled from the display's human-visible timing.
//
// Ports:
//   clk        in   rising-edge clock, the only clock
//   reset      in   synchronous, active-high reset
//   letter     in   [4:0] decoded letter code (0=a .. 25=z), valid while done=1
//   done       in   decoder completion level; each 0->1 transition pushes
//   clear      in   synchronous flush, same effect as reset
//   cur_letter out  [4:0] letter currently shown (meaningful while cur_valid=1)
//   cur_valid  out  high while a letter is being shown
//   count      out  [ADDR_W:0] number of queued, not-yet-shown letters
//   full       out  count == DEPTH
//   empty      out  count == 0
//   overflow   out  sticky; set when a push is dropped on a full FIFO
//
// Codes 26..31 are not range-checked; they are stored and shown unchanged.
// ---------------------------------------------------------------------------
module morse_letter_scroller #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int HOLD   = 16,
  parameter int GAP    = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        letter,
  input  logic              done,
  input  logic              clear,
  output logic [4:0]        cur_letter,
  output logic              cur_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0]  TIMER_ONE = CNT_W'(1);

  // Letter storage. No reset so it maps onto distributed/block RAM. The read
  // port is the registered cur_letter load in the FSM below.
  logic [4:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              done_q_reg;
  logic [CNT_W-1:0]  timer_reg;
  state_t            state_reg;
  logic [4:0]        cur_letter_reg;
  logic              cur_valid_reg;
  logic              overflow_reg;
  logic              full_reg;
  logic              empty_reg;

  logic              push;
  logic              pop;
  logic              push_ok;
  logic [ADDR_W:0]   count_next;

  // Push/pop decisions use only registered state plus the done/letter inputs.
  // Nothing here feeds an output combinationally.
  always_comb begin
    push       = done & ~done_q_reg;
    // pop depends on the registered count. A letter written into an empty
    // FIFO therefore cannot be popped until the following cycle.
    pop        = (state_reg == ST_IDLE) && (count_reg != '0);
    // When the FIFO is full, a push is still accepted if the same edge pops.
    // The pop reads the old slot contents while the push overwrites that
    // slot, because rd_ptr == wr_ptr when the FIFO is full.
    push_ok    = push && ((count_reg != DEPTH_C) || pop);
    count_next = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + COUNT_ONE;
    end else if (!push_ok && pop) begin
      count_next = count_reg - COUNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= letter;
    end
  end

  // FIFO bookkeeping and display FSM. Reset and clear act identically.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      done_q_reg     <= 1'b0;
      timer_reg      <= '0;
      state_reg      <= ST_IDLE;
      cur_letter_reg <= '0;
      cur_valid_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
      full_reg       <= 1'b0;
      empty_reg      <= 1'b1;
    end else begin
      done_q_reg <= done;
      count_reg  <= count_next;
      full_reg   <= (count_next == DEPTH_C);
      empty_reg  <= (count_next == '0);

      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (push && !push_ok) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          cur_valid_reg <= 1'b0;
          if (pop) begin
            cur_letter_reg <= mem[rd_ptr_reg];
            rd_ptr_reg     <= rd_ptr_reg + PTR_ONE;
            timer_reg      <= HOLD_LOAD;
            cur_valid_reg  <= 1'b1;
            state_reg      <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          // The timer is loaded with HOLD-1 and leaves on zero. The letter
          // is therefore visible for exactly HOLD cycles.
          if (timer_reg == '0) begin
            timer_reg     <= GAP_LOAD;
            cur_valid_reg <= 1'b0;
            state_reg     <= ST_GAP;
          end else begin
            timer_reg <= timer_reg - TIMER_ONE;
          end
        end
        ST_GAP: begin
          // cur_letter keeps its last value here. Only cur_valid is low.
          if (timer_reg == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg - TIMER_ONE;
          end
        end
        default: begin
          cur_valid_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cur_letter = cur_letter_reg;
  assign cur_valid  = cur_valid_reg;
  assign count      = count_reg;
  assign full       = full_reg;
  assign empty      = empty_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_morse_letter_scroller.sv
// ---------------------------------------------------------------------------
// tb_morse_letter_scroller
//
// Two instances are used:
//   dut_a : DEPTH=4, HOLD=4,   GAP=2
//   dut_b : DEPTH=4, HOLD=100, GAP=2 (overflow scenario)
//
// Expected letters are queued when a push is driven. A monitor per instance
// pops and compares them at each rising edge of cur_valid, and it also
// checks the width of each show window.
// ---------------------------------------------------------------------------
module tb_morse_letter_scroller;

  localparam int HOLD_A = 4;
  localparam int HOLD_B = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] a_letter = '0;
  logic       a_done = 1'b0;
  logic       a_clear = 1'b0;
  logic [4:0] a_cur_letter;
  logic       a_cur_valid;
  logic [2:0] a_count;
  logic       a_full, a_empty, a_overflow;

  logic [4:0] b_letter = '0;
  logic       b_done = 1'b0;
  logic       b_clear = 1'b0;
  logic [4:0] b_cur_letter;
  logic       b_cur_valid;
  logic [2:0] b_count;
  logic       b_full, b_empty, b_overflow;

  morse_letter_scroller #(.DEPTH(4), .ADDR_W(2), .HOLD(HOLD_A), .GAP(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .letter(a_letter), .done(a_done), .clear(a_clear),
    .cur_letter(a_cur_letter), .cur_valid(a_cur_valid), .count(a_count),
    .full(a_full), .empty(a_empty), .overflow(a_overflow)
  );

  morse_letter_scroller #(.DEPTH(4), .ADDR_W(2), .HOLD(HOLD_B), .GAP(2), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .letter(b_letter), .done(b_done), .clear(b_clear),
    .cur_letter(b_cur_letter), .cur_valid(b_cur_valid), .count(b_count),
    .full(b_full), .empty(b_empty), .overflow(b_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboards and show-window monitors.
  logic [4:0] a_q[$];
  logic [4:0] b_q[$];
  int a_rises = 0, a_width = 0;
  int b_rises = 0, b_width = 0;
  bit a_prev = 1'b0, a_skip = 1'b0;
  bit b_prev = 1'b0, b_skip = 1'b0;

  always @(negedge clk) begin
    logic [4:0] exp_l;
    if (a_cur_valid === 1'b1) begin
      if (!a_prev) begin
        a_rises++;
        a_width = 0;
        a_skip  = 1'b0;
        check_val("a_sb_nonempty", 32'(a_q.size() != 0), 1);
        if (a_q.size() != 0) begin
          exp_l = a_q.pop_front();
          check_val("a_letter", a_cur_letter, exp_l);
          $display("a show letter=%0d expected=%0d t=%0t", a_cur_letter, exp_l, $time);
        end
      end
      a_width++;
      if (a_clear) a_skip = 1'b1;
    end else if (a_prev && !a_skip) begin
      check_val("a_hold", a_width, HOLD_A);
    end
    a_prev = (a_cur_valid === 1'b1);
  end

  always @(negedge clk) begin
    logic [4:0] exp_l;
    if (b_cur_valid === 1'b1) begin
      if (!b_prev) begin
        b_rises++;
        b_width = 0;
        b_skip  = 1'b0;
        check_val("b_sb_nonempty", 32'(b_q.size() != 0), 1);
        if (b_q.size() != 0) begin
          exp_l = b_q.pop_front();
          check_val("b_letter", b_cur_letter, exp_l);
          $display("b show letter=%0d expected=%0d t=%0t", b_cur_letter, exp_l, $time);
        end
      end
      b_width++;
      if (b_clear) b_skip = 1'b1;
    end else if (b_prev && !b_skip) begin
      check_val("b_hold", b_width, HOLD_B);
    end
    b_prev = (b_cur_valid === 1'b1);
  end

  int sched_full [7] = '{0, 2, 4, 6, 8, 10, 15};
  int r0;

  initial begin
    // Reset state
    reset = 1'b1;
    tick(3);
    check_val("rst_count", a_count, 0);
    check_val("rst_empty", a_empty, 1);
    check_val("rst_full", a_full, 0);
    check_val("rst_valid", a_cur_valid, 0);
    check_val("rst_ovf", a_overflow, 0);
    check_val("rst_letter", a_cur_letter, 0);
    reset = 1'b0;
    tick(5);

    // Single letter: push in cycle N
    a_letter = 5'd4; a_done = 1'b1; a_q.push_back(5'd4);
    tick(1);                                     // N+1
    check_val("single_count1", a_count, 1);
    check_val("single_valid_n1", a_cur_valid, 0);
    check_val("single_empty_n1", a_empty, 0);
    a_done = 1'b0;
    tick(1);                                     // N+2
    check_val("single_valid_n2", a_cur_valid, 1);
    check_val("single_letter", a_cur_letter, 4);
    check_val("single_count0", a_count, 0);
    check_val("single_empty", a_empty, 1);
    tick(3);                                     // N+5
    check_val("single_valid_n5", a_cur_valid, 1);
    tick(1);                                     // N+6
    check_val("single_valid_n6", a_cur_valid, 0);
    check_val("single_hold_letter", a_cur_letter, 4);
    tick(1);                                     // N+7
    check_val("single_valid_n7", a_cur_valid, 0);
    tick(1);                                     // N+8 (IDLE)
    check_val("single_valid_n8", a_cur_valid, 0);
    tick(5);

    // Level done: only one push
    r0 = a_rises;
    a_letter = 5'd7; a_done = 1'b1; a_q.push_back(5'd7);
    tick(20);
    a_done = 1'b0;
    tick(15);
    check_val("level_windows", a_rises - r0, 1);
    check_val("level_count", a_count, 0);

    // Queue order and pointer wrap
    r0 = a_rises;
    for (int i = 0; i < 6; i++) begin
      a_letter = 5'(i); a_done = 1'b1; a_q.push_back(5'(i));
      tick(1);
      a_done = 1'b0;
      tick(6);
    end
    tick(10);
    check_val("wrap_windows", a_rises - r0, 6);
    check_val("wrap_ovf", a_overflow, 0);
    check_val("wrap_sb_empty", 32'(a_q.size()), 0);
    check_val("wrap_count", a_count, 0);
    tick(5);

    // Full FIFO with a push coinciding with the IDLE pop (cycle M+15)
    for (int c = 0; c < 16; c++) begin
      a_done = 1'b0;
      for (int k = 0; k < 7; k++) begin
        if (sched_full[k] == c) begin
          a_done = 1'b1;
          a_letter = 5'(11 + k);
          a_q.push_back(5'(11 + k));
        end
      end
      tick(1);
      if (c == 10) begin
        check_val("full_count_m11", a_count, 4);
        check_val("full_flag_m11", a_full, 1);
      end
      if (c == 15) begin
        check_val("fullpop_count", a_count, 4);
        check_val("fullpop_full", a_full, 1);
        check_val("fullpop_ovf", a_overflow, 0);
      end
    end
    a_done = 1'b0;
    tick(54);
    check_val("fullpop_drain_count", a_count, 0);
    check_val("fullpop_drain_empty", a_empty, 1);
    check_val("fullpop_sb_empty", 32'(a_q.size()), 0);
    tick(3);

    // Clear mid-SHOW with three letters queued
    for (int c = 0; c < 10; c++) begin
      a_done = 1'b0;
      if ((c % 2) == 0) begin
        a_done = 1'b1;
        a_letter = 5'(1 + c / 2);
        a_q.push_back(5'(1 + c / 2));
      end
      tick(1);
    end
    a_done = 1'b0;                               // M+10
    check_val("clr_pre_count", a_count, 3);
    check_val("clr_pre_valid", a_cur_valid, 1);
    a_clear = 1'b1;
    a_q.delete();
    tick(1);                                     // M+11
    check_val("clr_valid", a_cur_valid, 0);
    check_val("clr_count", a_count, 0);
    check_val("clr_empty", a_empty, 1);
    check_val("clr_ovf", a_overflow, 0);
    a_clear = 1'b0;
    a_letter = 5'd25; a_done = 1'b1; a_q.push_back(5'd25);
    tick(1);
    a_done = 1'b0;
    tick(1);                                     // two cycles after the edge
    check_val("clr_new_valid", a_cur_valid, 1);
    check_val("clr_new_letter", a_cur_letter, 25);
    tick(10);
    check_val("a_sb_final_empty", 32'(a_q.size()), 0);

    // Overflow on the long-hold instance
    for (int c = 0; c < 11; c++) begin
      b_done = 1'b0;
      if ((c % 2) == 0) begin
        b_done = 1'b1;
        b_letter = 5'(10 + c / 2);
        if (c < 10) b_q.push_back(5'(10 + c / 2));
      end
      tick(1);
      if (c == 8) begin
        check_val("ovf_full_m9", b_full, 1);
        check_val("ovf_count_m9", b_count, 4);
      end
      if (c == 9) check_val("ovf_before", b_overflow, 0);
      if (c == 10) begin
        check_val("ovf_set", b_overflow, 1);
        check_val("ovf_count_kept", b_count, 4);
        check_val("ovf_full_kept", b_full, 1);
      end
    end
    b_done = 1'b0;
    tick(560);
    check_val("ovf_windows", b_rises, 5);
    check_val("ovf_sb_empty", 32'(b_q.size()), 0);
    check_val("ovf_sticky", b_overflow, 1);
    check_val("ovf_drain_empty", b_empty, 1);

    // Reset clears the sticky overflow flag
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_val("ovf_reset", b_overflow, 0);
    check_val("ovf_reset_count", b_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
